// File: rtl/cdc_pkg.sv
// Shared definitions for the 4-phase clock-domain-crossing transmitter.
// Holds the handshake state type, the default word width and timeout,
// and a helper that sizes the phase counter.
package cdc_pkg;

   localparam int CDC_WIDTH_DEF       = 8;
   localparam int CDC_TIMEOUT_DEF     = 255;
   localparam int CDC_SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      REQ_LO = 2'd2
   } cdc_state_e;

   // Bits needed to hold 0..timeout; never narrower than one bit so a
   // disabled timeout still yields a legal counter.
   function automatic int cdc_cnt_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer for an asynchronous level.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears every stage
//   d    - asynchronous input
//   q    - synchronized output (last stage)
// SYNC_STAGES is expected in 2..4.
module cdc_sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Transmit side of a 4-phase req/ack handshake into a remote clock domain.
// A word accepted on in_valid/in_ready is held on data_o while req_o is
// raised; the remote's ack is synchronized, req_o is dropped, and once the
// ack falls again the transfer completes with a done_o pulse.
// Each phase is bounded by TIMEOUT cycles (0 disables); a timeout sets the
// sticky err_o flag.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   ena               - allows new acceptances (in-flight transfer continues)
//   in_valid/in_data  - local word offer
//   in_ready          - word accepted on this edge if in_valid
//   req_o/data_o      - registered request and held word to remote
//   ack_i             - asynchronous acknowledge from remote
//   done_o            - one-cycle completion pulse
//   err_o/err_clr     - sticky timeout flag and its clear
//
// state  | meaning
// IDLE   | waiting for a word; in_ready needs ena and a low synced ack
// REQ_HI | req_o high, waiting for synced ack to rise
// REQ_LO | req_o low, waiting for synced ack to fall
module cdc_hs_tx
   import cdc_pkg::*;
#(
   parameter int WIDTH       = CDC_WIDTH_DEF,
   parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF,
   parameter int TIMEOUT     = CDC_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             req_o,
   output logic [WIDTH-1:0] data_o,
   input  logic             ack_i,
   output logic             done_o,
   output logic             err_o,
   input  logic             err_clr
);

   localparam int CNT_W = cdc_cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   // Timeout fires on the edge at which the counter would reach TIMEOUT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   cdc_state_e       state_q, state_d;
   logic             req_q, req_d;
   logic [WIDTH-1:0] data_q;
   logic             load;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             abort_q, abort_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ack_s;
   logic             timeout_hit;

   cdc_sync_bit #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack_i),
      .q   (ack_s)
   );

   assign in_ready    = (state_q == IDLE) && ena && !ack_s;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   // A request that timed out never saw an ack, so a low ack in REQ_LO means
   // nothing for it. abort_q makes such a transfer sit out the full REQ_LO
   // timeout as a quiet period for the remote, then return without done_o.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      load    = 1'b0;
      done_d  = 1'b0;
      abort_d = abort_q;
      err_d   = err_clr ? 1'b0 : err_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               load    = 1'b1;
               req_d   = 1'b1;
               abort_d = 1'b0;
               state_d = REQ_HI;
            end
         end
         REQ_HI: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = REQ_LO;
            end else if (timeout_hit) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               abort_d = 1'b1;
               state_d = REQ_LO;
            end
         end
         REQ_LO: begin
            if (!abort_q && !ack_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q != IDLE) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         done_q  <= done_d;
         err_q   <= err_d;
         abort_q <= abort_d;
         cnt_q   <= cnt_d;
         if (load) begin
            data_q <= in_data;
         end
      end
   end

   assign req_o  = req_q;
   assign data_o = data_q;
   assign done_o = done_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
module tb_cdc_hs_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       req_o;
   logic [7:0] data_o;
   logic       ack_i;
   logic       done_o;
   logic       err_o;
   logic       err_clr;

   logic       loop_en;
   logic       ack_force;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   assign ack_i = loop_en ? req_o : ack_force;

   always #5 clk = ~clk;

   cdc_hs_tx #(
      .WIDTH       (8),
      .SYNC_STAGES (2),
      .TIMEOUT     (10)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .req_o    (req_o),
      .data_o   (data_o),
      .ack_i    (ack_i),
      .done_o   (done_o),
      .err_o    (err_o),
      .err_clr  (err_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic accept(input logic [7:0] w, input bit sb_push);
      in_valid = 1'b1;
      in_data  = w;
      #1;
      check("accept_ready", in_ready, 1);
      if (sb_push) exp_q.push_back(w);
      @(negedge clk);
      in_valid = 1'b0;
      check("accept_req", req_o, 1);
      check("accept_data", data_o, w);
   endtask

   // Latency counted in edges after the accept edge; also checks the pulse
   // is a single cycle (consumes one more cycle after the pulse).
   task automatic wait_done(input string tag, input int exp_lat);
      int k;
      logic [7:0] e;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done_o === 1'b1) break;
      end
      check({tag, "_latency"}, k, exp_lat);
      if (k <= 40) begin
         check({tag, "_req_low_at_done"}, req_o, 0);
         check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, data_o, e);
         end
         check({tag, "_err"}, err_o, 0);
         @(negedge clk);
         check({tag, "_pulse_width"}, done_o, 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      bit saw_done;
      rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      err_clr = 1'b0; loop_en = 1'b1; ack_force = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req", req_o, 0);
      check("rst_data", data_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_ready_ena0", in_ready, 0);
      rst = 1'b0;
      ena = 1'b1;
      #1;
      check("ready_ena1", in_ready, 1);

      // Loopback single word: done 2*2+2 = 6 cycles after acceptance.
      @(negedge clk);
      accept(8'hA5, 1);
      wait_done("loop_a5", 6);

      // ena dropped mid-transfer: transfer still completes, new offer ignored.
      accept(8'h3C, 1);
      ena = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h77;
      wait_done("ena_off", 6);
      repeat (3) begin
         @(negedge clk);
         check("ena_off_ready", in_ready, 0);
         check("ena_off_req", req_o, 0);
         check("ena_off_data", data_o, 8'h3C);
      end
      ena = 1'b1;
      accept(8'h77, 1);
      wait_done("ena_on", 6);

      // Back-to-back words with in_valid held high.
      in_valid = 1'b1;
      in_data = 8'h01;
      exp_q.push_back(8'h01);
      @(negedge clk);
      check("b2b_req1", req_o, 1);
      check("b2b_data1", data_o, 8'h01);
      in_data = 8'h02;
      exp_q.push_back(8'h02);
      wait_done("b2b_w1", 6);
      check("b2b_req2", req_o, 1);
      check("b2b_data2", data_o, 8'h02);
      in_data = 8'h03;
      exp_q.push_back(8'h03);
      wait_done("b2b_w2", 6);
      check("b2b_req3", req_o, 1);
      check("b2b_data3", data_o, 8'h03);
      in_valid = 1'b0;
      wait_done("b2b_w3", 6);

      // No ack: REQ_HI times out after 10 cycles, err_clr in the same cycle loses.
      loop_en = 1'b0;
      ack_force = 1'b0;
      accept(8'hC3, 0);
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         check("to_req_hold", req_o, 1);
      end
      check("to_err_before", err_o, 0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("to_req_fall", req_o, 0);
      check("to_err_vs_clr", err_o, 1);
      saw_done = 1'b0;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         saw_done = saw_done | done_o;
         if (in_ready === 1'b1) break;
      end
      check("to_lo_cycles", k, 10);
      check("to_no_done", saw_done, 0);
      check("to_err_sticky", err_o, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_clr", err_o, 0);

      // Stale ack arriving after a timeout blocks in_ready until it falls.
      accept(8'h5A, 0);
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (req_o === 1'b0) break;
      end
      check("stale_to_cycles", k, 10);
      check("stale_err", err_o, 1);
      ack_force = 1'b1;
      repeat (12) @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'hEE;
      repeat (4) begin
         @(negedge clk);
         check("stale_ready", in_ready, 0);
         check("stale_req", req_o, 0);
         check("stale_data", data_o, 8'h5A);
      end
      in_valid = 1'b0;
      ack_force = 1'b0;
      @(negedge clk);
      check("release_ready_1", in_ready, 0);
      @(negedge clk);
      check("release_ready_2", in_ready, 1);

      // Reset one cycle after acceptance aborts the transfer; err also clears.
      loop_en = 1'b1;
      accept(8'hFF, 0);
      rst = 1'b1;
      err_clr = 1'b0;
      @(negedge clk);
      check("abort_req", req_o, 0);
      check("abort_data", data_o, 0);
      check("abort_err", err_o, 0);
      check("abort_done", done_o, 0);
      rst = 1'b0;
      #1;
      check("abort_ready", in_ready, 1);
      repeat (8) begin
         @(negedge clk);
         check("abort_idle_req", req_o, 0);
         check("abort_idle_done", done_o, 0);
      end

      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
